i2c_line_rx: RTL and testbench

Synchronous I2C line receiver sitting directly upstream of the I2C slave protocol logic in the PWM controller. It brings raw SCL/SDA into the `clk_i` domain, removes glitches, and detects START/STOP. It assembles MSB-first bytes, presents each one with a one-cycle strobe, and drives the ACK bit on request. Downstream logic then works on clean byte events instead of sampling the bus on SCL edges.

---
 rtl/i2c_line_rx_pkg.sv | 20 ++
 rtl/i2c_line_rx_if.sv | 28 ++
 rtl/i2c_line_rx_filter.sv | 55 +++++
 rtl/i2c_line_rx.sv | 183 ++++++++++++++++++
 tb/tb_i2c_line_rx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_line_rx_pkg.sv
// Shared types and constants for the I2C line receiver.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_W          = 8;
  localparam int unsigned I2C_BIT_CNT_W       = $clog2(I2C_BYTE_W);
  localparam int unsigned I2C_SYNC_STAGES_DEF = 2;
  localparam int unsigned I2C_FILTER_LEN_DEF  = 3;

  typedef logic [I2C_BYTE_W-1:0]    i2c_byte_t;
  typedef logic [I2C_BIT_CNT_W-1:0] i2c_bit_cnt_t;

  // Receiver protocol states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_rx_if.sv
// Bus-side and consumer-side signals of the I2C line receiver.
interface i2c_line_rx_if;
  import i2c_pkg::*;

  logic      scl_i;
  logic      sda_i;
  logic      ack_i;
  logic      sda_oe_o;
  logic      start_o;
  logic      stop_o;
  i2c_byte_t byte_o;
  logic      byte_valid_o;
  logic      first_byte_o;
  logic      busy_o;

  // Receiver side.
  modport slave (
    input  scl_i, sda_i, ack_i,
    output sda_oe_o, start_o, stop_o, byte_o, byte_valid_o, first_byte_o, busy_o
  );

  // Pad / consumer side.
  modport master (
    output scl_i, sda_i, ack_i,
    input  sda_oe_o, start_o, stop_o, byte_o, byte_valid_o, first_byte_o, busy_o
  );

endinterface

// File: rtl/i2c_line_rx_filter.sv
// Synchronizer plus consecutive-sample glitch filter for one I2C line.
// Both stages reset to 1 (bus idle).
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw line through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
  end

  // Change the filtered level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer and filter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/i2c_line_rx.sv
// I2C line receiver: filters SCL/SDA, detects START/STOP, assembles
// MSB-first bytes with a one-cycle strobe and drives the ACK bit.
module i2c_line_rx
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = I2C_SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN  = I2C_FILTER_LEN_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  i2c_line_rx_if.slave  bus
);

  localparam i2c_bit_cnt_t LAST_BIT = i2c_bit_cnt_t'(I2C_BYTE_W - 1);

  logic scl_f, sda_f;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, scl_hold_hi;
  logic start_det, stop_det;

  i2c_state_e   state_q, state_d;
  i2c_byte_t    shift_q, shift_d, shift_next;
  i2c_bit_cnt_t cnt_q, cnt_d;
  logic         first_q, first_d;
  logic         ack_pend_q, ack_pend_d;

  logic         sda_oe_q, sda_oe_d;
  logic         start_q, start_d;
  logic         stop_q, stop_d;
  i2c_byte_t    byte_q, byte_d;
  logic         byte_valid_q, byte_valid_d;
  logic         first_byte_q, first_byte_d;
  logic         busy_q, busy_d;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (bus.scl_i),
    .line_o (scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (bus.sda_i),
    .line_o (sda_f)
  );

  // SDA edges only count as START/STOP when SCL was high in both cycles,
  // so a simultaneous SCL+SDA change is seen as an SCL edge only.
  assign scl_rise    =  scl_f & ~scl_prev_q;
  assign scl_fall    = ~scl_f &  scl_prev_q;
  assign scl_hold_hi =  scl_f &  scl_prev_q;
  assign start_det   = scl_hold_hi &  sda_prev_q & ~sda_f;
  assign stop_det    = scl_hold_hi & ~sda_prev_q &  sda_f;
  assign shift_next  = {shift_q[I2C_BYTE_W-2:0], sda_f};

  // Next-state logic; bus conditions take priority over every state.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_RECV;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RECV: if (ack_pend_q && scl_fall) state_d = bus.ack_i ? ST_ACK : ST_WAIT;
        ST_ACK:  if (scl_fall)               state_d = ST_RECV;
        default: ;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    ack_pend_d   = ack_pend_q;
    byte_d       = byte_q;
    busy_d       = busy_q;
    sda_oe_d     = sda_oe_q;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    byte_valid_d = 1'b0;
    first_byte_d = 1'b0;

    if (start_det) begin
      start_d    = 1'b1;
      busy_d     = 1'b1;
      cnt_d      = '0;
      first_d    = 1'b1;
      ack_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (stop_det) begin
      stop_d     = 1'b1;
      busy_d     = 1'b0;
      cnt_d      = '0;
      first_d    = 1'b0;
      ack_pend_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_RECV: begin
          // After a full byte, the next SCL fall is the ACK decision point.
          if (ack_pend_q) begin
            if (scl_fall) begin
              ack_pend_d = 1'b0;
              sda_oe_d   = bus.ack_i;
            end
          end else if (scl_rise) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + i2c_bit_cnt_t'(1);
            if (cnt_q == LAST_BIT) begin
              byte_valid_d = 1'b1;
              byte_d       = shift_next;
              first_byte_d = first_q;
              ack_pend_d   = 1'b1;
            end
          end
        end
        ST_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            first_d  = 1'b0;
            cnt_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      shift_q      <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      ack_pend_q   <= 1'b0;
      sda_oe_q     <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      first_byte_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_prev_q   <= scl_f;
      sda_prev_q   <= sda_f;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      ack_pend_q   <= ack_pend_d;
      sda_oe_q     <= sda_oe_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      first_byte_q <= first_byte_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sda_oe_o     = sda_oe_q;
  assign bus.start_o      = start_q;
  assign bus.stop_o       = stop_q;
  assign bus.byte_o       = byte_q;
  assign bus.byte_valid_o = byte_valid_q;
  assign bus.first_byte_o = first_byte_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_line_rx.sv
// Directed bench for i2c_line_rx: drives an I2C master on raw SCL/SDA and
// checks strobes, START/STOP pulses, ACK drive and reset behaviour.
module tb_i2c_line_rx;
  import i2c_pkg::*;

  localparam int Q   = 10;  // quarter SCL period in clk cycles
  localparam int LAT = 6;   // raw edge -> registered output (2 sync + 3 filter + 1)

  logic clk = 1'b0;
  logic rst;
  logic sda_m;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  i2c_line_rx_if bus ();

  // Open-drain SDA: master level wired-AND with the receiver's pull-down.
  assign bus.sda_i = sda_m & ~bus.sda_oe_o;

  i2c_line_rx #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int n_start = 0, n_stop = 0, n_strobe = 0, n_oe_rise = 0, n_bad_first = 0;
  int start_cyc = 0, strobe_cyc = 0, oe_rise_cyc = 0, oe_run = 0, oe_len = 0;
  logic oe_prev = 1'b0;
  logic [7:0] log_byte [64];
  logic       log_first [64];

  always @(negedge clk) begin
    if (bus.start_o === 1'b1) begin
      n_start++;
      start_cyc = cyc;
    end
    if (bus.stop_o === 1'b1) n_stop++;
    if (bus.byte_valid_o === 1'b1) begin
      if (n_strobe < 64) begin
        log_byte[n_strobe]  = bus.byte_o;
        log_first[n_strobe] = bus.first_byte_o;
      end
      strobe_cyc = cyc;
      n_strobe++;
    end
    if (bus.first_byte_o === 1'b1 && bus.byte_valid_o !== 1'b1) n_bad_first++;
    if (bus.sda_oe_o === 1'b1) begin
      if (!oe_prev) begin
        n_oe_rise++;
        oe_rise_cyc = cyc;
        oe_run = 0;
      end
      oe_run++;
      oe_prev = 1'b1;
    end else begin
      if (oe_prev) oe_len = oe_run;
      oe_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  t_rise, t_fall, t_start;
  bit  glitch_en = 1'b0;

  task automatic send_bit(input logic b);
    sda_m = b;
    if (glitch_en) begin
      wait_cyc(3); bus.scl_i = 1'b1; wait_cyc(2); bus.scl_i = 1'b0; wait_cyc(Q - 5);
    end else begin
      wait_cyc(Q);
    end
    bus.scl_i = 1'b1;
    t_rise = cyc;
    if (glitch_en) begin
      wait_cyc(7); bus.scl_i = 1'b0; wait_cyc(2); bus.scl_i = 1'b1; wait_cyc(2 * Q - 9);
    end else begin
      wait_cyc(2 * Q);
    end
    bus.scl_i = 1'b0;
    t_fall = cyc;
    wait_cyc(Q);
  endtask

  // Eight data bits MSB first, then the released ACK bit.
  task automatic send_byte(input logic [7:0] b, output int r8, output int f8);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    r8 = t_rise;
    f8 = t_fall;
    send_bit(1'b1);
  endtask

  task automatic start_cond();
    sda_m = 1'b0;
    t_start = cyc;
    wait_cyc(2 * Q);
    bus.scl_i = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic rep_start_cond();
    sda_m = 1'b1;
    wait_cyc(Q);
    bus.scl_i = 1'b1;
    wait_cyc(2 * Q);
    sda_m = 1'b0;
    t_start = cyc;
    wait_cyc(2 * Q);
    bus.scl_i = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_cyc(Q);
    bus.scl_i = 1'b1;
    wait_cyc(2 * Q);
    sda_m = 1'b1;
    wait_cyc(2 * Q);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_sda_oe"},     bus.sda_oe_o,     1'b0);
    check({pfx, "_start"},      bus.start_o,      1'b0);
    check({pfx, "_stop"},       bus.stop_o,       1'b0);
    check({pfx, "_byte"},       bus.byte_o,       8'h00);
    check({pfx, "_byte_valid"}, bus.byte_valid_o, 1'b0);
    check({pfx, "_first"},      bus.first_byte_o, 1'b0);
    check({pfx, "_busy"},       bus.busy_o,       1'b0);
  endtask

  int bs, bst, bsp, bo, r8, f8;

  initial begin
    rst       = 1'b1;
    bus.scl_i = 1'b1;
    bus.ack_i = 1'b1;
    sda_m     = 1'b1;
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(20);
    check("idle_busy", bus.busy_o, 1'b0);

    // Address 0x40 write (0x80), data 0x06 and 0xFF, then STOP.
    bs = n_strobe; bst = n_start; bsp = n_stop; bo = n_oe_rise;
    start_cond();
    check("t1_start_cnt", n_start - bst, 1);
    check("t1_start_lat", start_cyc - t_start, LAT);
    check("t1_busy", bus.busy_o, 1'b1);
    send_byte(8'h80, r8, f8);
    check("t1_addr_cnt", n_strobe - bs, 1);
    check("t1_addr_byte", log_byte[bs], 8'h80);
    check("t1_addr_first", log_first[bs], 1'b1);
    check("t1_strobe_lat", strobe_cyc - r8, LAT);
    check("t1_oe_cnt", n_oe_rise - bo, 1);
    check("t1_oe_lat", oe_rise_cyc - f8, LAT);
    check("t1_oe_len", oe_len, 4 * Q);
    send_byte(8'h06, r8, f8);
    send_byte(8'hFF, r8, f8);
    check("t1_strobe_cnt", n_strobe - bs, 3);
    check("t1_d0_byte", log_byte[bs + 1], 8'h06);
    check("t1_d0_first", log_first[bs + 1], 1'b0);
    check("t1_d1_byte", log_byte[bs + 2], 8'hFF);
    check("t1_d1_first", log_first[bs + 2], 1'b0);
    check("t1_oe_cnt3", n_oe_rise - bo, 3);
    stop_cond();
    check("t1_stop_cnt", n_stop - bsp, 1);
    check("t1_busy_end", bus.busy_o, 1'b0);
    wait_cyc(20);

    // NACK on the address: no ACK drive, further data ignored until STOP.
    bs = n_strobe; bst = n_start; bo = n_oe_rise;
    bus.ack_i = 1'b0;
    start_cond();
    send_byte(8'hA0, r8, f8);
    check("t2_addr_cnt", n_strobe - bs, 1);
    check("t2_addr_byte", log_byte[bs], 8'hA0);
    check("t2_addr_first", log_first[bs], 1'b1);
    send_byte(8'h55, r8, f8);
    check("t2_no_strobe", n_strobe - bs, 1);
    check("t2_no_oe", n_oe_rise - bo, 0);
    check("t2_busy", bus.busy_o, 1'b1);
    stop_cond();
    check("t2_busy_end", bus.busy_o, 1'b0);
    bus.ack_i = 1'b1;
    wait_cyc(20);
    start_cond();
    check("t2_restart_cnt", n_start - bst, 2);
    send_byte(8'h42, r8, f8);
    check("t2_new_cnt", n_strobe - bs, 2);
    check("t2_new_byte", log_byte[bs + 1], 8'h42);
    check("t2_new_first", log_first[bs + 1], 1'b1);
    check("t2_new_oe", n_oe_rise - bo, 1);
    stop_cond();
    wait_cyc(20);

    // 2-cycle SCL glitches in every low and high phase.
    bs = n_strobe;
    start_cond();
    glitch_en = 1'b1;
    send_byte(8'hA5, r8, f8);
    send_byte(8'h3C, r8, f8);
    glitch_en = 1'b0;
    stop_cond();
    check("t3_strobe_cnt", n_strobe - bs, 2);
    check("t3_b0", log_byte[bs], 8'hA5);
    check("t3_b0_first", log_first[bs], 1'b1);
    check("t3_b1", log_byte[bs + 1], 8'h3C);
    check("t3_b1_first", log_first[bs + 1], 1'b0);
    wait_cyc(20);

    // Repeated START after 4 data bits aborts the partial byte.
    bs = n_strobe; bst = n_start;
    start_cond();
    send_byte(8'h80, r8, f8);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rep_start_cond();
    check("t4_abort_no_strobe", n_strobe - bs, 1);
    check("t4_start_cnt", n_start - bst, 2);
    check("t4_rs_lat", start_cyc - t_start, LAT);
    send_byte(8'h91, r8, f8);
    check("t4_strobe_cnt", n_strobe - bs, 2);
    check("t4_byte", log_byte[bs + 1], 8'h91);
    check("t4_first", log_first[bs + 1], 1'b1);
    stop_cond();
    wait_cyc(20);

    // Reset in the middle of the ACK bit.
    bs = n_strobe; bo = n_oe_rise;
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 7);
    check("t5_pre_oe", bus.sda_oe_o, 1'b1);
    sda_m = 1'b1;
    rst = 1'b1;
    wait_cyc(1);
    check_all_zero("t5_rst");
    rst = 1'b0;
    send_bit(1'b1);
    send_byte(8'hFF, r8, f8);
    check("t5_ignored_strobe", n_strobe - bs, 1);
    check("t5_ignored_oe", n_oe_rise - bo, 1);
    check("t5_ignored_busy", bus.busy_o, 1'b0);
    bus.scl_i = 1'b1;
    wait_cyc(2 * Q);
    start_cond();
    send_byte(8'h22, r8, f8);
    check("t5_fresh_cnt", n_strobe - bs, 2);
    check("t5_fresh_byte", log_byte[bs + 1], 8'h22);
    check("t5_fresh_first", log_first[bs + 1], 1'b1);
    stop_cond();
    wait_cyc(20);

    check("first_without_valid", n_bad_first, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
